codec_dac_sched: RTL and testbench
==================================

CODEC_DAC_SCHED -- requirements
Module: codec_dac_sched

Interface
REQ-001 SHALL have no parameters; widths fixed: 48-bit stereo frame ([23:0] = lrclk-low half, [47:24] = lrclk-high half).
REQ-002 clk  in  1  single system clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 s0_valid  in  1  source 0 (modulator) frame available.
REQ-005 s0_data  in  48  source 0 stereo frame.
REQ-006 s0_ready  out  1  source 0 frame accepted this cycle.
REQ-007 s1_valid  in  1  source 1 (loopback/test) frame available.
REQ-008 s1_data  in  48  source 1 stereo frame.
REQ-009 s1_ready  out  1  source 1 frame accepted this cycle.
REQ-010 mode  in  2  00 src0 only, 01 src1 only, 10 round-robin, 11 mute.
REQ-011 dac_lrclk  in  1  codec LR clock, used for slot/underrun detection.
REQ-012 dac_din_ack  in  2  per-half consume pulses from the codec interface.
REQ-013 dac_din_valid  out  2  both bits equal; 2'b11 while a frame is held.
REQ-014 dac_din  out  48  held frame, stable while held.
REQ-015 active_src  out  1  source of the currently held frame.
REQ-016 underrun_cnt  out  16  count of LR slots started with no frame held.

Function
REQ-017 State machine SHALL have states EMPTY, FULL (no half acked), PART (one half acked).
REQ-018 In EMPTY, grant SHALL go to the source selected by mode: 00 -> src0 if s0_valid; 01 -> src1 if s1_valid; 10 -> the valid source, with both valid going to the source not granted last; 11 -> none.
REQ-019 sN_ready SHALL be combinational = (state==EMPTY) & grantN; at most one ready high per cycle.
REQ-020 On a grant edge: hold register <= sN_data, active_src <= N, state -> FULL; dac_din_valid = 2'b11 from the next cycle.
REQ-021 The round-robin last-grant pointer SHALL update only on grants made in mode 10, and SHALL reset to 1, so src0 wins the first tie.
REQ-022 dac_din_valid SHALL be 2'b11 in FULL and PART, and 2'b00 in EMPTY.
REQ-023 dac_din SHALL hold its value until the frame retires; when EMPTY it SHALL show the last frame, or 0 after reset.
REQ-024 FULL + any single ack bit -> PART; the acked bit SHALL be recorded in a 2-bit mask.
REQ-025 PART + the other ack bit -> EMPTY (frame retired); a repeat of the already-recorded bit SHALL be ignored.
REQ-026 dac_din_ack == 2'b11 in FULL -> EMPTY directly.
REQ-027 A frame MAY start on either half: halves are consumed in codec order and both SHALL go out exactly once.
REQ-028 Retire-to-next-grant SHALL take 1 cycle: EMPTY on the cycle after the retiring ack, grant possible in that cycle.
REQ-029 Acks arriving in EMPTY SHALL be ignored.
REQ-030 A mode change SHALL take effect at the next grant; a held frame SHALL always complete, including after a switch to mute.
REQ-031 A dac_lrclk edge (either direction, detected with one registered copy) while in EMPTY and mode != 11 SHALL increment underrun_cnt.
REQ-032 underrun_cnt SHALL saturate at 16'hFFFF.
REQ-033 An edge coinciding with a grant in the same cycle SHALL still count as an underrun.

Reset
REQ-034 rst SHALL force: state EMPTY, mask 0, hold register 0, active_src 0, rr pointer 1, underrun_cnt 0, lrclk delay register 0.
REQ-035 While rst is high, s0_ready, s1_ready and dac_din_valid SHALL be 0.
REQ-036 rst asserted mid-frame SHALL discard the held frame; the first frame after reset SHALL come from a new grant.

Verification
REQ-037 mode=00, s0_valid=1, s0_data=48'hABCDEF_123456 -> s0_ready 1 cycle; dac_din_valid=11 next cycle; after ack=01 then ack=10 -> EMPTY and s0_ready again 1 cycle later.
REQ-038 mode=10, both sources valid continuously -> grants alternate src0, src1, src0, ...; active_src follows the same sequence.
REQ-039 mode=00, s0_valid=0 for 4 lrclk edges -> underrun_cnt=4, dac_din_valid=00; mode=11 for 4 further edges -> count stays 4.
REQ-040 Held frame with ack=10 first, then 10 repeated, then 01 -> retires only on the 01, and dac_din stays stable throughout.
REQ-041 Mode switched 00->11 while FULL -> frame completes both acks, then no further grants and s0_ready stays 0.
REQ-042 rst pulsed while in PART -> next cycle dac_din_valid=00, dac_din=0, underrun_cnt=0; next grant loads a fresh frame.

Source files
------------

// File: rtl/codec_dac_sched.sv
// Stereo frame scheduler for the codec DAC path.
// Selects frames from two sources, holds one frame at a time until the codec
// has consumed both halves, and counts LR slots that start with nothing held.
module codec_dac_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic [47:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [47:0] s1_data,
    output logic        s1_ready,
    input  logic [1:0]  mode,
    input  logic        dac_lrclk,
    input  logic [1:0]  dac_din_ack,
    output logic [1:0]  dac_din_valid,
    output logic [47:0] dac_din,
    output logic        active_src,
    output logic [15:0] underrun_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // nothing held
        FULL  = 2'd1,  // frame held, neither half consumed
        PART  = 2'd2   // frame held, one half consumed
    } state_t;

    localparam logic [1:0] MODE_SRC0 = 2'b00;
    localparam logic [1:0] MODE_SRC1 = 2'b01;
    localparam logic [1:0] MODE_RR   = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    state_t      state, state_next;
    logic [1:0]  mask, mask_next;
    logic [47:0] hold_q;
    logic        rr_last;
    logic        lrclk_q;
    logic        grant0, grant1;
    logic        lrclk_edge;

    // Grant arbitration: only an empty holder can accept a frame.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == EMPTY) begin
            case (mode)
                MODE_SRC0: grant0 = s0_valid;
                MODE_SRC1: grant1 = s1_valid;
                MODE_RR: begin
                    if (s0_valid && s1_valid) begin
                        // Tie goes to whichever source was not served last.
                        grant0 = rr_last;
                        grant1 = ~rr_last;
                    end else begin
                        grant0 = s0_valid;
                        grant1 = s1_valid;
                    end
                end
                default: ;  // mute: no grants
            endcase
        end
    end

    // Next-state and half-consumed mask tracking.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        case (state)
            EMPTY: begin
                if (grant0 || grant1) begin
                    state_next = FULL;
                    mask_next  = 2'b00;
                end
            end
            FULL: begin
                if (dac_din_ack == 2'b11) begin
                    state_next = EMPTY;
                    mask_next  = 2'b00;
                end else if (dac_din_ack != 2'b00) begin
                    state_next = PART;
                    mask_next  = dac_din_ack;
                end
            end
            PART: begin
                // Only the half not yet consumed retires the frame; repeats are ignored.
                if ((dac_din_ack & ~mask) != 2'b00) begin
                    state_next = EMPTY;
                    mask_next  = 2'b00;
                end
            end
            default: begin
                state_next = EMPTY;
                mask_next  = 2'b00;
            end
        endcase
    end

    // State register and consumed-half mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= EMPTY;
            mask  <= 2'b00;
        end else begin
            state <= state_next;
            mask  <= mask_next;
        end
    end

    // Frame capture on grant, plus the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= 48'd0;
            active_src <= 1'b0;
            rr_last    <= 1'b1;
        end else if (grant0 || grant1) begin
            hold_q     <= grant1 ? s1_data : s0_data;
            active_src <= grant1;
            if (mode == MODE_RR) begin
                rr_last <= grant1;
            end
        end
    end

    assign lrclk_edge = dac_lrclk ^ lrclk_q;

    // LR slot edge detection and saturating underrun counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrclk_q      <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            lrclk_q <= dac_lrclk;
            if (lrclk_edge && (state == EMPTY) && (mode != MODE_MUTE)
                && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    // Handshake outputs are forced low while reset is held, before state settles.
    assign s0_ready      = grant0 & ~rst;
    assign s1_ready      = grant1 & ~rst;
    assign dac_din_valid = {2{(state != EMPTY) && !rst}};
    assign dac_din       = hold_q;

endmodule

// File: tb/tb_codec_dac_sched.sv
// Directed testbench for codec_dac_sched with hand-computed expectations.
module tb_codec_dac_sched;

    logic        clk;
    logic        rst;
    logic        s0_valid;
    logic [47:0] s0_data;
    logic        s0_ready;
    logic        s1_valid;
    logic [47:0] s1_data;
    logic        s1_ready;
    logic [1:0]  mode;
    logic        dac_lrclk;
    logic [1:0]  dac_din_ack;
    logic [1:0]  dac_din_valid;
    logic [47:0] dac_din;
    logic        active_src;
    logic [15:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    codec_dac_sched dut (
        .clk          (clk),
        .rst          (rst),
        .s0_valid     (s0_valid),
        .s0_data      (s0_data),
        .s0_ready     (s0_ready),
        .s1_valid     (s1_valid),
        .s1_data      (s1_data),
        .s1_ready     (s1_ready),
        .mode         (mode),
        .dac_lrclk    (dac_lrclk),
        .dac_din_ack  (dac_din_ack),
        .dac_din_valid(dac_din_valid),
        .dac_din      (dac_din),
        .active_src   (active_src),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge and move 1 ns past it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        s0_valid    = 1'b1;
        s0_data     = 48'hABCDEF_123456;
        s1_valid    = 1'b1;
        s1_data     = 48'h0;
        mode        = 2'b00;
        dac_lrclk   = 1'b0;
        dac_din_ack = 2'b00;

        // Reset behaviour
        step();
        step();
        check("rst_s0_ready", s0_ready, 1'b0);
        check("rst_s1_ready", s1_ready, 1'b0);
        check("rst_valid", dac_din_valid, 2'b00);
        check("rst_din", dac_din, 48'h0);
        check("rst_active", active_src, 1'b0);
        check("rst_underrun", underrun_cnt, 16'd0);

        // Basic src0 frame, acked 01 then 10
        rst = 1'b0;
        s1_valid = 1'b0;
        settle();
        check("t1_s0_ready", s0_ready, 1'b1);
        check("t1_s1_ready", s1_ready, 1'b0);
        step();
        check("t1_valid_full", dac_din_valid, 2'b11);
        check("t1_din", dac_din, 48'hABCDEF_123456);
        check("t1_active", active_src, 1'b0);
        check("t1_ready_full", s0_ready, 1'b0);
        dac_din_ack = 2'b01;
        step();
        check("t1_valid_part", dac_din_valid, 2'b11);
        dac_din_ack = 2'b10;
        step();
        dac_din_ack = 2'b00;
        settle();
        check("t1_valid_empty", dac_din_valid, 2'b00);
        check("t1_regrant", s0_ready, 1'b1);
        check("t1_din_last", dac_din, 48'hABCDEF_123456);

        // Ack 10, repeated 10, then 01: retires only on 01
        s0_data = 48'h111111_222222;
        step();
        check("t2_din", dac_din, 48'h111111_222222);
        dac_din_ack = 2'b10;
        step();
        check("t2_part_valid", dac_din_valid, 2'b11);
        step();
        check("t2_repeat_valid", dac_din_valid, 2'b11);
        check("t2_repeat_ready", s0_ready, 1'b0);
        check("t2_repeat_din", dac_din, 48'h111111_222222);
        dac_din_ack = 2'b01;
        s0_valid = 1'b0;
        step();
        dac_din_ack = 2'b00;
        settle();
        check("t2_retired", dac_din_valid, 2'b00);
        check("t2_din_kept", dac_din, 48'h111111_222222);

        // Acks in EMPTY are ignored
        dac_din_ack = 2'b11;
        step();
        dac_din_ack = 2'b00;
        settle();
        check("t3_empty_ack", dac_din_valid, 2'b00);

        // Both halves acked at once in FULL
        s0_valid = 1'b1;
        s0_data  = 48'h333333_444444;
        step();
        s0_valid = 1'b0;
        dac_din_ack = 2'b11;
        settle();
        check("t4_full", dac_din_valid, 2'b11);
        step();
        dac_din_ack = 2'b00;
        settle();
        check("t4_retired", dac_din_valid, 2'b00);

        // Round-robin, both valid: src0, src1, src0, src1
        mode     = 2'b10;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_data  = 48'hA0A0A0_A0A0A0;
        s1_data  = 48'hB1B1B1_B1B1B1;
        for (int i = 0; i < 4; i++) begin
            logic exp_src;
            exp_src = (i % 2 == 1);
            settle();
            check($sformatf("rr%0d_s0_ready", i), s0_ready, !exp_src);
            check($sformatf("rr%0d_s1_ready", i), s1_ready, exp_src);
            step();
            check($sformatf("rr%0d_active", i), active_src, exp_src);
            check($sformatf("rr%0d_din", i), dac_din,
                  exp_src ? 48'hB1B1B1_B1B1B1 : 48'hA0A0A0_A0A0A0);
            dac_din_ack = 2'b11;
            step();
            dac_din_ack = 2'b00;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        step();

        // Underruns: 4 lrclk edges in mode 00, then 4 in mute
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            dac_lrclk = ~dac_lrclk;
            step();
        end
        check("ur_count4", underrun_cnt, 16'd4);
        check("ur_valid", dac_din_valid, 2'b00);
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            dac_lrclk = ~dac_lrclk;
            step();
        end
        check("ur_mute_count", underrun_cnt, 16'd4);

        // Edge coinciding with a grant still counts
        mode      = 2'b00;
        s0_valid  = 1'b1;
        s0_data   = 48'h555555_666666;
        dac_lrclk = ~dac_lrclk;
        step();
        check("ur_grant_count", underrun_cnt, 16'd5);
        check("ur_grant_valid", dac_din_valid, 2'b11);

        // Switch to mute while FULL: frame completes, no further grants
        mode = 2'b11;
        dac_din_ack = 2'b01;
        step();
        check("mute_part_valid", dac_din_valid, 2'b11);
        dac_din_ack = 2'b10;
        step();
        dac_din_ack = 2'b00;
        settle();
        check("mute_retired", dac_din_valid, 2'b00);
        check("mute_no_ready", s0_ready, 1'b0);
        step();
        step();
        check("mute_still_idle", dac_din_valid, 2'b00);
        check("mute_still_no_ready", s0_ready, 1'b0);

        // Reset in PART discards the frame
        mode    = 2'b00;
        s0_data = 48'h777777_888888;
        step();
        s0_valid = 1'b0;
        dac_din_ack = 2'b01;
        step();
        dac_din_ack = 2'b00;
        check("rp_part_valid", dac_din_valid, 2'b11);
        rst = 1'b1;
        settle();
        check("rp_valid_in_rst", dac_din_valid, 2'b00);
        step();
        rst = 1'b0;
        settle();
        check("rp_valid", dac_din_valid, 2'b00);
        check("rp_din", dac_din, 48'h0);
        check("rp_underrun", underrun_cnt, 16'd0);
        check("rp_active", active_src, 1'b0);
        s0_valid = 1'b1;
        s0_data  = 48'h999999_AAAAAA;
        settle();
        check("rp_regrant", s0_ready, 1'b1);
        step();
        s0_valid = 1'b0;
        check("rp_new_din", dac_din, 48'h999999_AAAAAA);
        check("rp_new_valid", dac_din_valid, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
